// File: rtl/drum_sequencer.sv
// Three-voice, 16-step drum pattern sequencer: synchronized pattern editing,
// start/stop playback and one-cycle trigger pulses per voice.
module drum_sequencer #(
  parameter int STEP_TICKS = 6_250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        drum,
  input  logic [3:0]  KEY,
  input  logic [5:0]  SW,
  output logic        kick_trig,
  output logic        snare_trig,
  output logic        hat_trig,
  output logic [3:0]  step,
  output logic        playing,
  output logic [15:0] step_leds
);

  localparam int CNT_W = $clog2(STEP_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_TICKS - 1);

  // Press pulse bit positions: KEY[0] toggle, KEY[1] run/stop, KEY[3] clear.
  localparam int P_TOG = 0;
  localparam int P_RUN = 1;
  localparam int P_CLR = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STOPPED,
    ST_PLAYING
  } state_e;

  logic [2:0]        key_s1_q, key_s2_q, key_d1_q, press_q;
  logic [5:0]        sw_s1_q, sw_s2_q;
  state_e            state_q, state_d;
  logic [3:0]        step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0][15:0]  rows_q, rows_d;
  logic [2:0]        trig_q, trig_d;
  logic [15:0]       leds_q, leds_d;
  logic              playing_q, playing_d;
  logic [1:0]        voice;
  logic [3:0]        cursor;

  // KEY[2] is owned by the mode selector.
  logic unused_key2;
  assign unused_key2 = KEY[2];

  function automatic logic [15:0] row_of(input logic [2:0][15:0] rows, input logic [1:0] v);
    case (v)
      2'd0:    return rows[0];
      2'd1:    return rows[1];
      2'd2:    return rows[2];
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [2:0] step_bits(input logic [2:0][15:0] rows, input logic [3:0] s);
    return {rows[2][s], rows[1][s], rows[0][s]};
  endfunction

  assign voice  = sw_s2_q[5:4];
  assign cursor = sw_s2_q[3:0];

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    rows_d  = rows_q;
    trig_d  = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (drum) state_d = ST_STOPPED;
      end
      ST_STOPPED: begin
        if (press_q[P_RUN]) begin
          state_d = ST_PLAYING;
          step_d  = 4'd0;
          cnt_d   = '0;
          trig_d  = step_bits(rows_q, 4'd0);
        end
      end
      ST_PLAYING: begin
        if (press_q[P_RUN]) begin
          state_d = ST_STOPPED;
          step_d  = 4'd0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          step_d = step_q + 4'd1;
          // Triggers read the rows as they stood before any same-cycle edit.
          trig_d = step_bits(rows_q, step_q + 4'd1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!drum) begin
      state_d = ST_IDLE;
      step_d  = 4'd0;
      cnt_d   = '0;
      trig_d  = 3'b000;
    end

    if (state_q != ST_IDLE) begin
      for (int v = 0; v < 3; v++) begin
        if (voice == 2'(v)) begin
          if (press_q[P_CLR])      rows_d[v] = 16'h0000;
          else if (press_q[P_TOG]) rows_d[v][cursor] = ~rows_q[v][cursor];
        end
      end
    end

    leds_d    = row_of(rows_d, voice);
    playing_d = (state_d == ST_PLAYING);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1_q  <= 3'b111;
      key_s2_q  <= 3'b111;
      key_d1_q  <= 3'b111;
      press_q   <= 3'b000;
      sw_s1_q   <= 6'd0;
      sw_s2_q   <= 6'd0;
      state_q   <= ST_IDLE;
      step_q    <= 4'd0;
      cnt_q     <= '0;
      rows_q    <= '0;
      trig_q    <= 3'b000;
      leds_q    <= 16'h0000;
      playing_q <= 1'b0;
    end else begin
      key_s1_q  <= {KEY[3], KEY[1], KEY[0]};
      key_s2_q  <= key_s1_q;
      key_d1_q  <= key_s2_q;
      press_q   <= key_d1_q & ~key_s2_q;
      sw_s1_q   <= SW;
      sw_s2_q   <= sw_s1_q;
      state_q   <= state_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      rows_q    <= rows_d;
      trig_q    <= trig_d;
      leds_q    <= leds_d;
      playing_q <= playing_d;
    end
  end

  assign kick_trig  = trig_q[0];
  assign snare_trig = trig_q[1];
  assign hat_trig   = trig_q[2];
  assign step       = step_q;
  assign playing    = playing_q;
  assign step_leds  = leds_q;

endmodule

// File: tb/tb_drum_sequencer.sv
// Scoreboard bench for drum_sequencer: an edge-indexed reference model queues
// expected outputs and trigger events; a monitor pops and compares them.
module tb_drum_sequencer;
  localparam int T = 4;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        drum = 1'b0;
  logic [3:0]  KEY  = 4'hF;
  logic [5:0]  SW   = 6'd0;
  logic        kick_trig, snare_trig, hat_trig, playing;
  logic [3:0]  step;
  logic [15:0] step_leds;

  always #5 clk = ~clk;

  drum_sequencer #(.STEP_TICKS(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .drum       (drum),
    .KEY        (KEY),
    .SW         (SW),
    .kick_trig  (kick_trig),
    .snare_trig (snare_trig),
    .hat_trig   (hat_trig),
    .step       (step),
    .playing    (playing),
    .step_leds  (step_leds)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  trg;
    logic [3:0]  stp;
    logic        ply;
    logic [15:0] leds;
  } rec_t;

  rec_t        sq[$];
  rec_t        tq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          m_state = 0;  // 0 idle, 1 stopped, 2 playing
  int          m_start = 0;  // edge at which playback last started
  logic [15:0] m_rows [3];
  logic [3:0]  kh [5];       // KEY pin value sampled at edge e-i
  logic [5:0]  sh [3];       // SW pin value sampled at edge e-i

  // Reference model: a press acts 3 edges after the pin is first seen low,
  // SW is seen 2 edges late, and the step is derived from elapsed edges.
  initial begin : model
    rec_t        r;
    logic [2:0]  pr;
    logic [1:0]  vc;
    logic [3:0]  cu;
    logic [15:0] pre [3];
    int          nxt, el;
    forever begin
      @(posedge clk);
      cyc++;
      r.cyc = cyc; r.trg = 3'b000; r.stp = 4'd0; r.ply = 1'b0; r.leds = 16'h0000;
      if (!rst) begin
        m_state = 0;
        for (int i = 0; i < 3; i++) begin m_rows[i] = 16'h0000; sh[i] = 6'd0; end
        for (int i = 0; i < 5; i++) kh[i] = 4'hF;
        sq.push_back(r);
      end else begin
        for (int i = 4; i > 0; i--) kh[i] = kh[i-1];
        kh[0] = KEY;
        for (int i = 2; i > 0; i--) sh[i] = sh[i-1];
        sh[0] = SW;
        pr = {kh[4][3] & ~kh[3][3], kh[4][1] & ~kh[3][1], kh[4][0] & ~kh[3][0]};
        vc = sh[2][5:4];
        cu = sh[2][3:0];
        for (int i = 0; i < 3; i++) pre[i] = m_rows[i];
        if (!drum)             nxt = 0;
        else if (m_state == 0) nxt = 1;
        else if (pr[1]) begin
          nxt = (m_state == 1) ? 2 : 1;
          if (nxt == 2) m_start = cyc;
        end else nxt = m_state;
        if (nxt == 2) begin
          el    = cyc - m_start;
          r.stp = 4'((el / T) % 16);
          r.ply = 1'b1;
          if (el % T == 0) r.trg = {pre[2][r.stp], pre[1][r.stp], pre[0][r.stp]};
        end
        if (m_state != 0 && vc != 2'd3) begin
          if (pr[2])      m_rows[int'(vc)] = 16'h0000;
          else if (pr[0]) m_rows[int'(vc)][cu] = ~m_rows[int'(vc)][cu];
        end
        if (vc != 2'd3) r.leds = m_rows[int'(vc)];
        m_state = nxt;
        sq.push_back(r);
        if (r.trg != 3'b000) tq.push_back(r);
      end
    end
  end

  initial begin : monitor
    rec_t       r, t;
    logic [2:0] got;
    forever begin
      @(negedge clk);
      got = {hat_trig, snare_trig, kick_trig};
      if (sq.size() > 0) begin
        r = sq.pop_front();
        n_cmp++;
        if (got !== r.trg || step !== r.stp || playing !== r.ply || step_leds !== r.leds) begin
          n_bad++;
          $display("FAIL status cyc=%0d got trg=%b step=%0d playing=%b leds=%h, want trg=%b step=%0d playing=%b leds=%h",
                   cyc, got, step, playing, step_leds, r.trg, r.stp, r.ply, r.leds);
        end
      end
      while (tq.size() > 0 && tq[0].cyc < cyc) begin
        t = tq.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed_trigger cyc=%0d got none, want trg=%b step=%0d", t.cyc, t.trg, t.stp);
      end
      if (got != 3'b000) begin
        n_cmp++;
        if (tq.size() > 0 && tq[0].cyc == cyc) begin
          t = tq.pop_front();
          if (got !== t.trg || step !== t.stp) begin
            n_bad++;
            $display("FAIL trigger cyc=%0d got trg=%b step=%0d, want trg=%b step=%0d", cyc, got, step, t.trg, t.stp);
          end
        end else begin
          n_bad++;
          $display("FAIL spurious_trigger cyc=%0d got trg=%b, want none", cyc, got);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic next();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_cyc(input int e);
    if (cyc > e) begin
      n_cmp++;
      n_bad++;
      $display("FAIL schedule got cyc=%0d, want <= %0d", cyc, e);
    end
    while (cyc < e) next();
  endtask

  task automatic press_bits(input logic [3:0] mask);
    KEY = KEY & ~mask;
    repeat (2) next();
    KEY = 4'hF;
    repeat (2) next();
  endtask

  task automatic press_at(input logic [3:0] mask, input int e);
    wait_cyc(e - 4);
    press_bits(mask);
  endtask

  task automatic set_sw(input logic [5:0] v);
    SW = v;
    repeat (3) next();
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %h, want %h", name, got, want);
    end
  endtask

  function automatic int find_edge(input int s, input int off);
    for (int e = cyc + 6; e < cyc + 6 + 17 * T; e++)
      if (((e - m_start) / T) % 16 == s && (e - m_start) % T == off) return e;
    return cyc + 6;
  endfunction

  initial begin : stim
    int e;
    repeat (3) next();
    rst = 1'b1;
    next();
    check("reset_step_leds", step_leds, 16'h0000);
    check("reset_playing", {15'd0, playing}, 16'h0000);
    drum = 1'b1;
    repeat (2) next();

    // Kick on steps 0 and 4, then play through a full wrap.
    set_sw(6'h00); press_bits(4'b0001);
    set_sw(6'h04); press_bits(4'b0001);
    check("kick_row", step_leds, 16'h0011);
    press_bits(4'b0010);
    repeat (70) next();
    press_at(4'b0010, find_edge(7, 1));
    repeat (3) next();
    check("stop_step", {12'd0, step}, 16'h0000);

    // Snare and hat on step 2, then drop drum together with a run press.
    set_sw(6'h12); press_bits(4'b0001);
    set_sw(6'h22); press_bits(4'b0001);
    press_bits(4'b0010);
    repeat (20) next();
    e = find_edge(3, 2);
    wait_cyc(e - 4);
    KEY[1] = 1'b0;
    wait_cyc(e - 1);
    drum = 1'b0;
    next();
    KEY = 4'hF;
    repeat (4) next();
    check("idle_playing", {15'd0, playing}, 16'h0000);
    drum = 1'b1;
    repeat (4) next();
    check("rows_kept", step_leds, 16'h0004);

    // Toggle kick step 5 in the very cycle playback advances onto it.
    set_sw(6'h05);
    press_bits(4'b0010);
    press_at(4'b0001, find_edge(5, 0));
    repeat (80) next();
    press_bits(4'b0010);

    // Clear beats toggle; voice 3 edits nothing.
    set_sw(6'h00);
    check("pre_clear", step_leds, 16'h0031);
    press_bits(4'b1001);
    check("clear_wins", step_leds, 16'h0000);
    press_bits(4'b0001);
    set_sw(6'h30);
    press_bits(4'b0001);
    press_bits(4'b1000);
    check("voice3_leds", step_leds, 16'h0000);
    set_sw(6'h00);
    check("voice3_no_edit", step_leds, 16'h0001);

    for (int i = 0; i < 60; i++) begin
      SW = 6'($urandom_range(0, 63));
      repeat (3) next();
      case ($urandom_range(0, 5))
        0, 1:    press_bits(4'b0001);
        2:       press_bits(4'b1000);
        3:       press_bits(4'b0010);
        4:       press_bits(4'($urandom_range(0, 15)));
        default: begin drum = ~drum; next(); end
      endcase
      repeat ($urandom_range(0, 6)) next();
    end

    // Asynchronous reset while playing at step 9.
    drum = 1'b1;
    repeat (3) next();
    if (m_state != 2) press_bits(4'b0010);
    wait_cyc(find_edge(9, 1));
    rst = 1'b0;
    #1;
    check("async_trigs", {13'd0, hat_trig, snare_trig, kick_trig}, 16'h0000);
    check("async_step", {12'd0, step}, 16'h0000);
    check("async_playing", {15'd0, playing}, 16'h0000);
    check("async_leds", step_leds, 16'h0000);
    repeat (2) next();
    rst = 1'b1;
    repeat (10) next();
    check("post_reset_playing", {15'd0, playing}, 16'h0000);
    repeat (4) next();
    check("pending_triggers", 16'(tq.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/drum_sequencer.md
# drum_sequencer

Three-voice, 16-step drum pattern sequencer that consumes the `drum` mode flag produced by the mode-select FSM. While drum mode is active, the user edits kick/snare/hi-hat patterns with SW and KEY[0]/[1]/[3] and starts or stops playback. The block emits one-cycle trigger pulses per voice to the downstream sample/tone generators. KEY[2] belongs to the mode selector and is ignored here.

## Interface
- `STEP_TICKS`, 6_250_000, clk cycles per step (120 BPM sixteenths at 50 MHz); must be ≥2.
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset; asynchronous, active-low.
- `drum`  in  1  drum-mode enable from the mode selector (registered, level).
- `KEY`  in  4  raw push buttons, active-low; bits 0, 1 and 3 are used.
- `SW`  in  6  SW[3:0] cursor step; SW[5:4] voice select (0 kick, 1 snare, 2 hat, 3 none).
- `kick_trig`, `snare_trig`, `hat_trig`  out  1 each  one-cycle trigger pulses.
- `step`  out  4  current playback step.
- `playing`  out  1  high in PLAYING.
- `step_leds`  out  16  pattern row of the selected voice (bit n = step n).

## Operation
- Inputs: KEY[3:0] and SW pass through 2-flop synchronizers. KEY synchronizers reset to 1 (released). A press is a synchronized 1→0 edge, giving one pulse per press. Buttons are debounced upstream.
- Storage: three 16-bit pattern rows, all zero at reset. Rows are retained across mode changes and IDLE.
- FSM states: IDLE, STOPPED, PLAYING.
  - IDLE → STOPPED when `drum`=1.
  - STOPPED → PLAYING on a KEY[1] press.
  - PLAYING → STOPPED on a KEY[1] press.
  - Any state → IDLE when `drum`=0. This has priority over a simultaneous KEY[1] press.
- Editing (STOPPED and PLAYING only; ignored in IDLE):
  - KEY[0] press toggles row[voice][cursor].
  - KEY[3] press clears row[voice].
  - If KEY[0] and KEY[3] land in the same cycle, clear wins.
  - With voice=3, both edits are ignored and `step_leds`=0.
- Playback:
  - On entry to PLAYING: `step`=0 and tick counter=0.
  - The counter counts 0..STEP_TICKS-1. At STEP_TICKS-1, `step` ← step+1 mod 16 (15 wraps to 0) and the counter ← 0.
  - For each step entered (including step 0 on entry), each `*_trig` = row[voice][new step].
- Leaving PLAYING (to STOPPED or IDLE): `step` ← 0, counter ← 0, no triggers.
- Edit vs. step collision: if an edit and a step advance onto the same bit occur in the same cycle, the trigger uses the pre-edit value. The edit takes effect from the next visit.

## Timing
- Reset values: `kick_trig`=`snare_trig`=`hat_trig`=0, `step`=0, `playing`=0, `step_leds`=0, state IDLE, all rows 0.
- All outputs are registered.
- Pin to press pulse: KEY pin falling edge → internal press pulse 3 cycles later (2 sync flops + edge register).
- Edit latency: press pulse → row bit updated and `step_leds` reflects it on the next cycle.
- Start latency: KEY[1] press pulse at cycle t gives:
  - `playing`=1 and `step`=0 at t+1;
  - triggers for step 0 high at t+1 only.
- Step spacing: step n+1 is presented exactly STEP_TICKS cycles after step n. Its triggers are high during the first cycle `step` shows the new value.
- Triggers are never wider than 1 cycle.
- `drum` falling: IDLE, `playing`=0 and `step`=0 one cycle later. No trigger in that cycle.
- Reset mid-operation: all state returns to reset values immediately (asynchronous), and pattern rows are cleared. No spurious press follows release, because the synchronizers reset to 1.

## Test plan
- **Reset, edit and play:** assert reset, release, `drum`=1. Set SW=6'b00_0000, press KEY[0]; set SW=6'b00_0100, press KEY[0]. Expect `step_leds`=16'h0011. Press KEY[1] with STEP_TICKS=4. Expect `kick_trig` pulses at steps 0 and 4 only, 16 cycles apart, and `step` wrapping 15→0 with a kick at wrap.
- **Voice independence:** set snare step 2 and hat step 2, then play. Expect `snare_trig` and `hat_trig` high in the same cycle as `step`=2, with `kick_trig`=0.
- **Clear priority:** press KEY[0] and KEY[3] in the same cycle on voice 0 with row=16'h0011. Expect row=0. With voice=3, KEY[0] leaves all rows unchanged and `step_leds`=0.
- **Stop and mode exit:** press KEY[1] while playing at step 7. Expect `playing`=0 and `step`=0 next cycle, with no triggers. Restart, then drop `drum` in the same cycle as a KEY[1] press. Expect IDLE and no triggers. Raise `drum` again: rows are preserved (`step_leds` unchanged).
- **Edit/advance collision:** toggle kick bit 5 (from 0) in the cycle the step advances to 5. Expect no `kick_trig` at that visit and `kick_trig` at the next visit to step 5.
- **Async reset mid-play:** assert reset while playing at step 9. Expect all outputs 0 immediately and rows cleared. After release, no press is detected with KEY held high.
